// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package rr_arbiter_4_pkg;

    // Number of requesters and the width of a requester index.
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    // Hold counter width: large enough for hold limits up to 15.
    localparam int unsigned HOLD_W  = 4;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [HOLD_W-1:0]  hold_cnt_t;

    // Arbiter FSM: no owner, or exactly one owner.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Requester index arithmetic; the 2-bit result wraps 3 -> 0 naturally.
    function automatic idx_t idx_add(input idx_t base, input idx_t offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// One-hot grant decode: turns the owner index into a 4-bit grant vector.
module grant_decoder_2to4
    import rr_arbiter_4_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    // Decode the owner index; all-zero whenever no grant is active.
    always_comb begin
        // NOTE: assigning a default before any conditional write keeps this block free of inferred latches.
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a per-grant hold limit.
// A grant lasts while the owner keeps its request high, up to MAX_HOLD
// cycles; at least one idle cycle always separates consecutive grants.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    // Maximum consecutive grant cycles for one owner; legal range 1..15.
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid,
    output logic               tmo
);

    // Value of hold_cnt on the last cycle an owner may keep the grant.
    localparam hold_cnt_t HOLD_LAST = hold_cnt_t'(MAX_HOLD - 1);

    arb_state_e state_q,    state_d;
    idx_t       owner_q,    owner_d;
    idx_t       ptr_q,      ptr_d;
    hold_cnt_t  hold_cnt_q, hold_cnt_d;
    logic       tmo_q,      tmo_d;

    logic       scan_hit;
    idx_t       scan_idx;
    logic       owner_req;

    // Priority scan starting at ptr: first requesting index of ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        idx_t cand;
        cand     = ptr_q;
        scan_hit = 1'b0;
        scan_idx = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = idx_add(ptr_q, idx_t'(i));
            if (!scan_hit && req[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    // Only the current owner's request line matters while a grant is held.
    assign owner_req = req[owner_q];

    // Next-state logic: grant on a hit in IDLE, release on drop or hold limit.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        tmo_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_hit) begin
                    state_d    = GRANT;
                    owner_d    = scan_idx;
                    hold_cnt_d = '0;
                end
            end

            GRANT: begin
                hold_cnt_d = hold_cnt_q + hold_cnt_t'(1);
                if (!owner_req) begin
                    // Voluntary release wins even on the hold-limit cycle, so no tmo here.
                    state_d = IDLE;
                    ptr_d   = idx_add(owner_q, idx_t'(1));
                end else if (hold_cnt_q == HOLD_LAST) begin
                    // Owner still wants the resource but has used its full budget.
                    state_d = IDLE;
                    ptr_d   = idx_add(owner_q, idx_t'(1));
                    tmo_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; owner index is kept while idle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    // All outputs come straight from flops (the decode is a pure function of them).
    assign gnt_valid = (state_q == GRANT);
    assign gnt_id    = owner_q;
    assign tmo       = tmo_q;

    grant_decoder_2to4 u_decoder (
        .idx    (owner_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4 (MAX_HOLD = 8 and MAX_HOLD = 1).
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req0;
    logic [3:0] req1;

    logic [3:0] gnt0, gnt1;
    logic [1:0] gnt_id0, gnt_id1;
    logic       gnt_valid0, gnt_valid1;
    logic       tmo0, tmo1;

    // Observed output bundles: {gnt, gnt_id, gnt_valid, tmo}
    logic [7:0] obs0, obs1;
    assign obs0 = {gnt0, gnt_id0, gnt_valid0, tmo0};
    assign obs1 = {gnt1, gnt_id1, gnt_valid1, tmo1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req0),
        .gnt       (gnt0),
        .gnt_id    (gnt_id0),
        .gnt_valid (gnt_valid0),
        .tmo       (tmo0)
    );

    rr_arbiter_4 #(.MAX_HOLD(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
        .gnt       (gnt1),
        .gnt_id    (gnt_id1),
        .gnt_valid (gnt_valid1),
        .tmo       (tmo1)
    );

    function automatic logic [7:0] exp_v(input logic [3:0] g, input logic [1:0] id,
                                         input logic v, input logic t);
        return {g, id, v, t};
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed gnt/id/valid/tmo=%b, expected %b", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] one;
        logic [1:0] id;

        rst  = 1'b1;
        req0 = 4'b0000;
        req1 = 4'b0000;
        tick();
        tick();
        check("reset_state", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));
        check("reset_state_h1", obs1, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));

        // Requests ignored while reset is held.
        req0 = 4'b1111;
        tick();
        check("req_ignored_in_reset", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));

        // Single requester 2, held three cycles.
        rst  = 1'b0;
        req0 = 4'b0100;
        tick();
        check("single_grant_c1", obs0, exp_v(4'b0100, 2'd2, 1'b1, 1'b0));
        tick();
        check("single_grant_c2", obs0, exp_v(4'b0100, 2'd2, 1'b1, 1'b0));
        tick();
        check("single_grant_c3", obs0, exp_v(4'b0100, 2'd2, 1'b1, 1'b0));
        req0 = 4'b0000;
        tick();
        check("single_release", obs0, exp_v(4'b0000, 2'd2, 1'b0, 1'b0));
        tick();
        check("idle_holds_id", obs0, exp_v(4'b0000, 2'd2, 1'b0, 1'b0));
        // ptr is now 3: all requesting picks requester 3.
        req0 = 4'b1111;
        tick();
        check("ptr_after_single", obs0, exp_v(4'b1000, 2'd3, 1'b1, 1'b0));
        req0 = 4'b0000;
        tick();
        check("release_3", obs0, exp_v(4'b0000, 2'd3, 1'b0, 1'b0));

        // Round robin from a fresh reset.
        rst = 1'b1;
        tick();
        check("reset_again", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));
        rst  = 1'b0;
        req0 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            one = 4'b0001 << (k % 4);
            id  = 2'(k % 4);
            tick();
            check($sformatf("rr_grant_%0d_c1", k), obs0, exp_v(one, id, 1'b1, 1'b0));
            tick();
            check($sformatf("rr_grant_%0d_c2", k), obs0, exp_v(one, id, 1'b1, 1'b0));
            req0 = 4'b1111 & ~one;
            tick();
            check($sformatf("rr_idle_%0d", k), obs0, exp_v(4'b0000, id, 1'b0, 1'b0));
            req0 = 4'b1111;
        end
        req0 = 4'b0000;
        rst  = 1'b1;
        tick();
        rst = 1'b0;

        // Hold limit: requester 0 held continuously.
        req0 = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("to_grant_c%0d", i), obs0, exp_v(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        tick();
        check("to_pulse", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b1));
        tick();
        check("to_regrant", obs0, exp_v(4'b0001, 2'd0, 1'b1, 1'b0));
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("coinc_grant_c%0d", i), obs0, exp_v(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        // Release on the hold-limit cycle: release wins, no tmo.
        req0 = 4'b0000;
        tick();
        check("coinc_release", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        check("coinc_after", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));

        // Reset mid-grant: ptr is 1, requester 3 becomes owner.
        req0 = 4'b1000;
        tick();
        check("mid_owner3", obs0, exp_v(4'b1000, 2'd3, 1'b1, 1'b0));
        req0 = 4'b1010;
        rst  = 1'b1;
        tick();
        check("mid_reset_drop", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));
        rst = 1'b0;
        tick();
        check("mid_reset_ptr0", obs0, exp_v(4'b0010, 2'd1, 1'b1, 1'b0));

        // Wrap-around: owner 1 drops (ptr -> 2), requester 3 owns until its limit.
        req0 = 4'b1000;
        tick();
        check("wrap_release1", obs0, exp_v(4'b0000, 2'd1, 1'b0, 1'b0));
        req0 = 4'b1001;
        tick();
        check("wrap_owner3", obs0, exp_v(4'b1000, 2'd3, 1'b1, 1'b0));
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("wrap_hold_c%0d", i), obs0, exp_v(4'b1000, 2'd3, 1'b1, 1'b0));
        end
        tick();
        check("wrap_tmo", obs0, exp_v(4'b0000, 2'd3, 1'b0, 1'b1));
        tick();
        check("wrap_to_0", obs0, exp_v(4'b0001, 2'd0, 1'b1, 1'b0));
        req0 = 4'b0000;
        tick();
        check("wrap_done", obs0, exp_v(4'b0000, 2'd0, 1'b0, 1'b0));

        // MAX_HOLD = 1: one-cycle grants, tmo whenever the owner still requests.
        req1 = 4'b0100;
        tick();
        check("h1_grant", obs1, exp_v(4'b0100, 2'd2, 1'b1, 1'b0));
        tick();
        check("h1_tmo", obs1, exp_v(4'b0000, 2'd2, 1'b0, 1'b1));
        tick();
        check("h1_regrant", obs1, exp_v(4'b0100, 2'd2, 1'b1, 1'b0));
        req1 = 4'b0000;
        tick();
        check("h1_release_no_tmo", obs1, exp_v(4'b0000, 2'd2, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of consecutive cycles one requester may hold the grant (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  4  per-requester request; bit k high = requester k wants the shared resource; level-held while wanted.
REQ-005 gnt  output  4  one-hot grant; bit k high = requester k owns the resource; all-zero when no owner.
REQ-006 gnt_id  output  2  binary index of current owner; valid only while gnt_valid is high.
REQ-007 gnt_valid  output  1  high while any grant is active.
REQ-008 tmo  output  1  one-cycle pulse on the cycle the grant is force-released by the hold limit.

Function
REQ-009 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-010 In IDLE with req == 0, the FSM SHALL remain in IDLE with gnt = 0.
REQ-011 In IDLE with req != 0, the FSM SHALL enter GRANT at the next edge, owner = first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 Latency SHALL be one cycle: req sampled high at edge N gives gnt high in the cycle after edge N.
REQ-013 gnt SHALL equal the 2-to-4 one-hot decode of gnt_id while gnt_valid = 1, and 4'b0000 otherwise; never more than one bit high.
REQ-014 hold_cnt (4 bits) SHALL load 0 on entry to GRANT and increment by 1 each GRANT cycle.
REQ-015 In GRANT, if req[gnt_id] = 0, the FSM SHALL return to IDLE at the next edge, with tmo = 0.
REQ-016 In GRANT, if req[gnt_id] = 1 and hold_cnt = MAX_HOLD-1, the FSM SHALL return to IDLE at the next edge and pulse tmo for that one following cycle.
REQ-017 On every GRANT->IDLE transition, ptr SHALL load (gnt_id + 1) mod 4, wrapping 3 to 0.
REQ-018 At least one IDLE cycle SHALL separate consecutive grants, including a grant to the same requester.
REQ-019 Requests other than the owner's SHALL be ignored during GRANT and SHALL NOT alter owner, hold_cnt or ptr.
REQ-020 When release and the hold limit coincide (req[gnt_id] drops on the cycle hold_cnt = MAX_HOLD-1), the release SHALL take priority and tmo SHALL stay 0.
REQ-021 With MAX_HOLD = 1, every grant SHALL last exactly one cycle, and tmo SHALL pulse whenever the owner's request is still high.
REQ-022 gnt_id SHALL hold its last value while gnt_valid = 0.

Reset
REQ-023 With rst high at an edge, the block SHALL go to IDLE with ptr = 0, hold_cnt = 0, gnt = 0, gnt_id = 0, gnt_valid = 0 and tmo = 0.
REQ-024 A reset during GRANT SHALL drop gnt in the cycle after the reset edge, and ptr SHALL return to 0 rather than advance.
REQ-025 While rst is high, req SHALL be ignored; arbitration restarts from ptr = 0 on the first edge with rst low.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, GRANT), the requester count constant (4) and the index width constant (2).
REQ-027 The one-hot grant decode SHALL be a separate sub-module, grant_decoder_2to4 (2-bit index plus enable in, 4-bit one-hot out).
REQ-028 The priority scan, FSM, hold counter and pointer SHALL be in rr_arbiter_4.

Verification
REQ-029 Single requester: after reset, req = 4'b0100 held for 3 cycles then dropped -> gnt = 4'b0100 and gnt_id = 2 from the cycle after the first sampling edge; gnt drops the cycle after req falls; ptr = 3.
REQ-030 Round robin: after reset, req = 4'b1111, with each owner dropping its bit after 2 cycles and raising it again -> grant order 0, 1, 2, 3, 0, with one IDLE cycle between grants.
REQ-031 Timeout: MAX_HOLD = 8, req = 4'b0001 held continuously -> gnt = 4'b0001 for exactly 8 cycles, tmo = 1 in the first cycle gnt = 0, one IDLE cycle, then requester 0 is re-granted.
REQ-032 Coincident release and limit: owner drops req on the cycle hold_cnt = 7 (MAX_HOLD = 8) -> gnt drops with tmo = 0.
REQ-033 Reset mid-grant: rst pulsed while requester 3 is owner, req = 4'b1010 held -> gnt = 0 for the cycle after the reset edge, then requester 1 is granted (ptr = 0 scan).
REQ-034 Wrap-around: owner 3 releases while req = 4'b1001 -> requester 0 is granted next, not requester 3.
